// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, line levels and default parameters for the UART transmit path.
// UART_TX_PARITY_EN adds the PARITY state to the state enum.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT_DEF = 868;
    localparam int UART_DATA_BITS_DEF    = 8;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_STOP_LEVEL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter, 0..CLKS_PER_BIT-1 with a tick on the last count.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] count
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick  = cnt == CW'(CLKS_PER_BIT - 1);
    assign count = cnt;

endmodule

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmitter, start / DATA_BITS LSB-first / stop, with registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = UART_DATA_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    uart_tx_state_e       state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_idx;
    logic [CW-1:0]        count;
    logic                 tick;
    logic                 last_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    // The counter is held at zero in IDLE and wraps on every tick, so it restarts with each state.
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clear(state == ST_IDLE),
        .tick(tick),
        .count(count)
    );

    assign last_bit = bit_idx == BW'(DATA_BITS - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            tx_o       <= UART_IDLE_LEVEL;
            tx_ready_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            // One cycle of lookahead so done_o lands on the final stop-bit cycle.
            done_o <= state == ST_STOP && count == CW'(CLKS_PER_BIT - 2);
            case (state)
                ST_IDLE: begin
                    if (tx_valid_i && tx_ready_o) begin
                        state      <= ST_START;
                        tx_o       <= UART_START_LEVEL;
                        tx_ready_o <= 1'b0;
                        busy_o     <= 1'b1;
                        shreg      <= tx_data_i;
                        bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
                        parity     <= ^tx_data_i;
`endif
                    end else begin
                        tx_ready_o <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx_o  <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (last_bit) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx_o  <= parity;
`else
                            state <= ST_STOP;
                            tx_o  <= UART_STOP_LEVEL;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_o    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        tx_o  <= UART_STOP_LEVEL;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state      <= ST_IDLE;
                        tx_o       <= UART_IDLE_LEVEL;
                        busy_o     <= 1'b0;
                        tx_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tx_o       <= UART_IDLE_LEVEL;
                    busy_o     <= 1'b0;
                    tx_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
